// File: rtl/window_scan_ctrl_pkg.sv
// Shared types for the raster-scan sequencer: FSM state encoding
// and default address widths.
package scan_pkg;

    localparam int COL_BITS_DEF = 10;
    localparam int ROW_BITS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Control and pixel-address stream bundle between the scan sequencer
// (master) and its driver/consumer (slave).
interface window_scan_ctrl_if
    import scan_pkg::*;
#(
    parameter int COL_BITS = COL_BITS_DEF,
    parameter int ROW_BITS = ROW_BITS_DEF
);

    logic                start;
    logic                abort;
    logic [COL_BITS-1:0] width_m1;
    logic [ROW_BITS-1:0] height_m1;
    logic                pix_valid;
    logic                pix_ready;
    logic [COL_BITS-1:0] pix_x;
    logic [ROW_BITS-1:0] pix_y;
    logic                eol;
    logic                eof;
    logic                busy;
    logic                done;

    modport master (
        input  start,
        input  abort,
        input  width_m1,
        input  height_m1,
        input  pix_ready,
        output pix_valid,
        output pix_x,
        output pix_y,
        output eol,
        output eof,
        output busy,
        output done
    );

    modport slave (
        output start,
        output abort,
        output width_m1,
        output height_m1,
        output pix_ready,
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  eol,
        input  eof,
        input  busy,
        input  done
    );

endinterface

// File: rtl/window_scan_ctrl_counter.sv
// Reloadable down counter used for the column and row positions.
// clear beats load, load beats dec; dec is never requested at zero.
module scan_down_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign zero = (r_cnt == '0);

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scan pixel-address sequencer with valid/ready output stream.
// Define SCAN_BORDER_SKIP_EN to suppress emission of frame-border pixels.
module window_scan_ctrl
    import scan_pkg::*;
#(
    parameter int COL_BITS = COL_BITS_DEF,
    parameter int ROW_BITS = ROW_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    window_scan_ctrl_if.master  scan
);

    scan_state_t         r_state;
    logic [COL_BITS-1:0] r_width;
    logic [ROW_BITS-1:0] r_height;
    logic                r_busy;
    logic                r_done;

    logic [COL_BITS-1:0] w_col_cnt;
    logic [ROW_BITS-1:0] w_row_cnt;
    logic                w_col_zero;
    logic                w_row_zero;
    logic                w_clear;
    logic                w_prime;
    logic                w_scan;
    logic                w_emit;
    logic                w_step;
    logic                w_row_wrap;
    logic                w_last;

    assign w_clear = rst | scan.abort;
    assign w_prime = (r_state == PRIME);
    assign w_scan  = (r_state == SCAN);

`ifdef SCAN_BORDER_SKIP_EN
    logic w_border;

    // x==0 corresponds to col_cnt==width, y==0 to row_cnt==height.
    assign w_border = w_col_zero
                    | w_row_zero
                    | (w_col_cnt == r_width)
                    | (w_row_cnt == r_height);
    assign w_emit   = w_scan & ~w_border;
    assign w_step   = (w_emit & scan.pix_ready)
                    | (w_scan & w_border);
`else
    assign w_emit   = w_scan;
    assign w_step   = w_scan & scan.pix_ready;
`endif

    assign w_row_wrap = w_step & w_col_zero & ~w_row_zero;
    assign w_last     = w_step & w_col_zero & w_row_zero;

    scan_down_counter #(
        .W (COL_BITS)
    ) u_col_cnt (
        .clk      (clk),
        .clear    (w_clear),
        .load     (w_prime | w_row_wrap),
        .load_val (r_width),
        .dec      (w_step & ~w_col_zero),
        .cnt      (w_col_cnt),
        .zero     (w_col_zero)
    );

    scan_down_counter #(
        .W (ROW_BITS)
    ) u_row_cnt (
        .clk      (clk),
        .clear    (w_clear),
        .load     (w_prime),
        .load_val (r_height),
        .dec      (w_row_wrap),
        .cnt      (w_row_cnt),
        .zero     (w_row_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_width  <= '0;
            r_height <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (scan.abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (scan.start) begin
                        r_state  <= PRIME;
                        r_width  <= scan.width_m1;
                        r_height <= scan.height_m1;
                        r_busy   <= 1'b1;
                    end
                end
                PRIME: begin
                    r_state <= SCAN;
                end
                SCAN: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Counters run down, so address = latched extent minus remaining count.
    assign scan.pix_x     = r_width - w_col_cnt;
    assign scan.pix_y     = r_height - w_row_cnt;
    assign scan.eol       = w_col_zero;
    assign scan.eof       = w_col_zero & w_row_zero;
    assign scan.pix_valid = w_emit;
    assign scan.busy      = r_busy;
    assign scan.done      = r_done;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: directed frames plus random
// frames/backpressure compared against a nested-loop raster model.
module tb_window_scan_ctrl;
    import scan_pkg::*;

`ifdef SCAN_BORDER_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_scan_ctrl_if sif ();

    window_scan_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .scan (sif)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int qx[$];
    int qy[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_emit(input int x, input int y,
                                      input int wm, input int hm);
        bit interior;
        interior = (x > 0) && (x < wm) && (y > 0) && (y < hm);
        return !SKIP || interior;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(sif.pix_valid), 0);
        check({tag, "_busy"},  32'(sif.busy), 0);
        check({tag, "_done"},  32'(sif.done), 0);
        check({tag, "_x"},     32'(sif.pix_x), 0);
        check({tag, "_y"},     32'(sif.pix_y), 0);
        check({tag, "_eol"},   32'(sif.eol), 1);
        check({tag, "_eof"},   32'(sif.eof), 1);
    endtask

    // mode 0: ready high, 1: ready 1,0,0 pattern, 2: random ready
    task automatic run_frame(input int wm, input int hm, input int mode,
                             input int abort_after);
        int  nx = 0;
        int  exp_n;
        int  budget;
        int  sx = 0;
        int  sy = 0;
        bit  stall = 1'b0;
        bit  exp_done = 1'b0;
        bit  saw_done = 1'b0;
        bit  rdy;
        qx.delete();
        qy.delete();
        for (int y = 0; y <= hm; y++)
            for (int x = 0; x <= wm; x++)
                if (model_emit(x, y, wm, hm)) begin
                    qx.push_back(x);
                    qy.push_back(y);
                end
        exp_n  = qx.size();
        budget = (wm + 1) * (hm + 1) * 4 + 20;

        sif.width_m1  = 10'(wm);
        sif.height_m1 = 10'(hm);
        sif.start     = 1'b1;
        tick();
        sif.start     = 1'b0;
        sif.width_m1  = 10'($urandom);
        sif.height_m1 = 10'($urandom);
        check("prime_busy",  32'(sif.busy), 1);
        check("prime_valid", 32'(sif.pix_valid), 0);
        tick();

        for (int cyc = 0; cyc < budget; cyc++) begin
            sif.start = 1'b0;
            if (abort_after >= 0 && nx == abort_after) begin
                sif.abort     = 1'b1;
                sif.pix_ready = 1'b0;
                tick();
                sif.abort = 1'b0;
                check("abort_valid", 32'(sif.pix_valid), 0);
                check("abort_busy",  32'(sif.busy), 0);
                check("abort_done",  32'(sif.done), 0);
                tick();
                check("abort_no_done", 32'(sif.done), 0);
                return;
            end
`ifndef SCAN_BORDER_SKIP_EN
            check("done_timing", 32'(sif.done), 32'(exp_done));
`endif
            if (sif.done) begin
                saw_done = 1'b1;
                check("xfer_count", nx, exp_n);
                tick();
                check("done_pulse", 32'(sif.done), 0);
                check("busy_drop",  32'(sif.busy), 0);
                break;
            end
            exp_done = 1'b0;
            if (stall) begin
                check("stall_valid", 32'(sif.pix_valid), 1);
                check("stall_x", 32'(sif.pix_x), sx);
                check("stall_y", 32'(sif.pix_y), sy);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sif.pix_ready = rdy;
            if (sif.pix_valid && rdy) begin
                if (qx.size() == 0) begin
                    check("overrun", 32'(nx), exp_n - 1);
                end else begin
                    check("pix_x", 32'(sif.pix_x), qx[0]);
                    check("pix_y", 32'(sif.pix_y), qy[0]);
                    check("eol", 32'(sif.eol), 32'(qx[0] == wm));
                    check("eof", 32'(sif.eof),
                          32'(qx[0] == wm && qy[0] == hm));
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    nx++;
                    if (qx.size() == 0) exp_done = 1'b1;
                end
            end
            stall = sif.pix_valid && !rdy;
            sx    = int'(sif.pix_x);
            sy    = int'(sif.pix_y);
            // Mid-scan start with fresh dimensions must be ignored.
            if (cyc == 2) begin
                sif.start    = 1'b1;
                sif.width_m1 = 10'($urandom);
            end
            tick();
        end
        sif.start = 1'b0;
        if (!saw_done) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        sif.start     = 1'b0;
        sif.abort     = 1'b0;
        sif.pix_ready = 1'b0;
        sif.width_m1  = '0;
        sif.height_m1 = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run_frame(3, 1, 0, -1);
        run_frame(3, 1, 1, -1);
        run_frame(0, 0, 0, -1);
        run_frame(3, 3, 0, 3);
        run_frame(3, 3, 2, -1);

        sif.abort = 1'b1;
        sif.start = 1'b1;
        tick();
        sif.abort = 1'b0;
        sif.start = 1'b0;
        check("abort_beats_start", 32'(sif.busy), 0);

        sif.width_m1      = 10'd3;
        sif.height_m1     = 10'd3;
        sif.start         = 1'b1;
        tick();
        sif.start         = 1'b0;
        sif.pix_ready     = 1'b1;
        repeat (4) tick();
        rst       = 1'b1;
        sif.start = 1'b1;
        tick();
        check_reset_outputs("midrst");
        tick();
        rst       = 1'b0;
        sif.start = 1'b0;
        tick();
        check("rst_start_ignored", 32'(sif.busy), 0);

        run_frame(4, 3, 0, -1);
        run_frame(1, 1, 0, -1);

        for (int i = 0; i < 8; i++)
            run_frame($urandom_range(0, 5), $urandom_range(0, 4),
                      $urandom_range(0, 2), -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Raster-scan sequencer for the edge-detector front end: on `start` it walks every pixel of a frame of programmable size, top-left to bottom-right. It drives a valid/ready pixel-address stream into the line-buffer/kernel stage and pulses `done` after the last pixel is accepted. Column and row positions are tracked with two reloadable down counters, and the block sequences their load, decrement and reload.

## Interface
Parameters:
- `COL_BITS`, 10: width of column count/address.
- `ROW_BITS`, 10: width of row count/address.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a frame scan; honoured only in IDLE.
- `abort`  in  1  terminate scan; return to IDLE without `done`.
- `width_m1`  in  COL_BITS  frame width minus 1; sampled on accepted `start`.
- `height_m1`  in  ROW_BITS  frame height minus 1; sampled on accepted `start`.
- `pix_valid`  out  1  `pix_x`/`pix_y` hold a pixel address for downstream.
- `pix_ready`  in  1  downstream accepts the address this cycle.
- `pix_x`  out  COL_BITS  column address, ascending from 0.
- `pix_y`  out  ROW_BITS  row address, ascending from 0.
- `eol`  out  1  current pixel is the last of its row.
- `eof`  out  1  current pixel is the last of the frame.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on frame completion.

## Operation
- FSM states: IDLE, PRIME, SCAN, DONE.
- IDLE→PRIME on `start`. Dimensions are latched into `w_r`/`h_r`.
- PRIME: column counter loads `w_r`, row counter loads `h_r`. Always →SCAN next cycle.
- SCAN: `pix_valid`=1. A transfer occurs when `pix_valid && pix_ready`.
- On transfer with col_cnt≠0: col_cnt decrements.
- On transfer with col_cnt=0, row_cnt≠0: col_cnt reloads `w_r` and row_cnt decrements.
- On transfer with both counters 0: →DONE.
- DONE: `done`=1 for one cycle, then →IDLE.
- Address outputs: `pix_x = w_r − col_cnt`, `pix_y = h_r − row_cnt` (width-preserving, no overflow possible).
- Flags: `eol = (col_cnt==0)`, `eof = eol && (row_cnt==0)`. Both are qualified only when `pix_valid` is high.
- Handshake rule: while `pix_valid` is high and `pix_ready` is low, `pix_x`, `pix_y`, `eol` and `eof` hold stable. `pix_valid` never drops before the transfer.
- `start` outside IDLE is ignored, and latched dimensions do not change mid-frame.
- `abort` in any non-IDLE state → IDLE next cycle, with no `done` and `pix_valid`=0 next cycle.
- Simultaneous `abort` and `start` in IDLE: `abort` wins and the block stays in IDLE.
- Priority: `rst` > `abort` > normal sequencing.
- `width_m1`=0 or `height_m1`=0 is legal: single column, single row, or single pixel (first pixel has `eol`=`eof`=1).

## Timing
- Reset values: state IDLE, counters 0, `w_r`/`h_r` 0, `pix_valid`=0, `busy`=0, `done`=0, `pix_x`=`pix_y`=0, `eol`=`eof`=1 (derived from zero counters; unqualified).
- `start` sampled at edge N → `busy`=1 at N+1 (PRIME) → first `pix_valid` at N+2.
- With `pix_ready` held high: one address per cycle. A W×H frame occupies W·H SCAN cycles, `done` appears on the cycle after the final transfer, and `busy` drops one cycle after `done`.
- Back-to-back frames: `start` may be asserted in the cycle `busy` first reads 0.
- Synchronous `rst` asserted mid-scan: all outputs take reset values at the next edge.

## Configuration
- `SCAN_BORDER_SKIP_EN` defined:
  - Pixels with x=0, x=`w_r`, y=0 or y=`h_r` are still stepped through, but `pix_valid` is held 0 for them.
  - The counters advance through border pixels at one per cycle with no handshake.
  - Only interior pixels, the valid 3×3 kernel centres, are emitted. Frames with `width_m1`<2 or `height_m1`<2 emit nothing and still pulse `done`.
- Undefined: every pixel is emitted as in Operation.

## Structure
- Package `scan_pkg`: FSM state enum `scan_state_t` (IDLE, PRIME, SCAN, DONE), and `COL_BITS_DEF`/`ROW_BITS_DEF` default width constants.
- Sub-module `scan_down_counter`, instantiated twice (column, row):
  - Inputs: `load`, `load_val`, `dec`, `clear`.
  - Outputs: `cnt`, `zero`.
  - `clear` (driven by `rst`/`abort`) overrides `load`, which overrides `dec`. Decrement at 0 is never requested.
- FSM, address subtraction and border qualification live in the top module.

## Test plan
- `width_m1`=3, `height_m1`=1, `pix_ready`=1 → 8 transfers with (x,y) = (0,0)…(3,0),(0,1)…(3,1); `eol` on x=3, `eof` only on (3,1); `done` one cycle after the 8th transfer.
- Same frame, `pix_ready` toggling 1,0,0,1… → same address sequence; address and `pix_valid` stable during every stall; no pixel dropped or duplicated.
- `width_m1`=0, `height_m1`=0 → single transfer (0,0) with `eol`=`eof`=1, then `done`.
- `abort` asserted after the 3rd transfer of a 4×4 frame → `pix_valid`=0 and `busy`=0 next cycle, no `done`; a new `start` then scans from (0,0). Also assert `start` mid-scan → ignored.
- Synchronous `rst` during SCAN → all outputs reach reset values after one edge; `start` with `rst` high → ignored.
- With `SCAN_BORDER_SKIP_EN`, a 5×4 frame (4,3) → only (1,1),(2,1),(3,1),(1,2),(2,2),(3,2) emitted; a 2×2 frame → no `pix_valid`, `done` still pulses.
